// File: rtl/riscv_hart_core.sv
// riscv_hart_core: single-issue, non-pipelined RV32I hart built as a
// three-state multi-cycle FSM. It drives an instruction memory and a data
// memory, both with one-cycle registered read latency.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   instruction  fetched word, valid one cycle after pc is presented
//   pc           byte address of the current instruction
//   mem_read     load data, valid one cycle after mem_addr is presented
//   mem_addr     data byte address (low bits passed through, word memory)
//   mem_data     store data
//   mem_write    store strobe, high only during EXEC of a store
//
// state | meaning
// FETCH | pc presented; memory captures the instruction at this edge
// EXEC  | decode, read rs1/rs2, compute, write back or start a load
// MEM   | load data returned; write rd and advance pc

package riscv_hart_pkg;
  typedef logic [31:0] instruction_t;
endpackage

module riscv_hart_core
  import riscv_hart_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  instruction_t          instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic [WIDTH-1:0]      mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data,
  output logic                  mem_write
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]      regs [32];
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      data_q;
  logic [4:0]            rd_q;

  logic                  rf_we;
  logic [4:0]            rf_wa;
  logic [WIDTH-1:0]      rf_wd;

  // Decode fields
  logic [6:0]            opcode;
  logic [4:0]            rd, rs1, rs2;
  logic [2:0]            funct3;
  logic [WIDTH-1:0]      rs1_v, rs2_v;
  logic [WIDTH-1:0]      imm_i, imm_s, imm_u;
  logic [ADDR_WIDTH-1:0] imm_b, imm_j;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  // x0 is held at zero by reset and never written, so a plain read suffices.
  assign rs1_v = regs[rs1];
  assign rs2_v = regs[rs2];

  assign imm_i = WIDTH'($signed(instruction[31:20]));
  assign imm_s = WIDTH'($signed({instruction[31:25], instruction[11:7]}));
  assign imm_u = WIDTH'($signed({instruction[31:12], 12'h000}));
  assign imm_b = ADDR_WIDTH'($signed({instruction[31], instruction[7],
                                      instruction[30:25], instruction[11:8], 1'b0}));
  assign imm_j = ADDR_WIDTH'($signed({instruction[31], instruction[19:12],
                                      instruction[20], instruction[30:21], 1'b0}));

  // ALU shared by OP and OP-IMM
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;

  assign op_b  = (opcode == OPC_OP) ? rs2_v : imm_i;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (funct3)
      3'd0: alu_res = (opcode == OPC_OP && instruction[30]) ? rs1_v - op_b : rs1_v + op_b;
      3'd1: alu_res = rs1_v << shamt;
      3'd2: alu_res = WIDTH'($signed(rs1_v) < $signed(op_b));
      3'd3: alu_res = WIDTH'(rs1_v < op_b);
      3'd4: alu_res = rs1_v ^ op_b;
      // instruction[30] selects arithmetic shift for both SRA and SRAI
      3'd5: alu_res = instruction[30] ? WIDTH'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
      3'd6: alu_res = rs1_v | op_b;
      3'd7: alu_res = rs1_v & op_b;
      default: alu_res = '0;
    endcase
  end

  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0: br_taken = (rs1_v == rs2_v);
      3'd1: br_taken = (rs1_v != rs2_v);
      3'd4: br_taken = ($signed(rs1_v) <  $signed(rs2_v));
      3'd5: br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6: br_taken = (rs1_v <  rs2_v);
      3'd7: br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  logic [ADDR_WIDTH-1:0] pc_plus4;
  assign pc_plus4 = pc + ADDR_WIDTH'(4);

  // Next-state / output logic. mem_addr and mem_data are driven from the
  // holding registers except during EXEC of a load/store, so the memory sees
  // the new address in the same cycle the strobe is raised.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    rf_we     = 1'b0;
    rf_wa     = rd;
    rf_wd     = '0;
    mem_write = 1'b0;
    mem_addr  = addr_q;
    mem_data  = data_q;

    unique case (state_q)
      S_FETCH: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OPC_OP_IMM, OPC_OP: begin
            rf_we = 1'b1;
            rf_wd = alu_res;
          end
          OPC_LUI: begin
            rf_we = 1'b1;
            rf_wd = imm_u;
          end
          OPC_AUIPC: begin
            rf_we = 1'b1;
            rf_wd = WIDTH'(pc) + imm_u;
          end
          OPC_JAL: begin
            rf_we = 1'b1;
            rf_wd = WIDTH'(pc_plus4);
            pc_d  = pc + imm_j;
          end
          OPC_JALR: begin
            // rs1_v is read before the write-back edge, so rd==rs1 is safe
            rf_we = 1'b1;
            rf_wd = WIDTH'(pc_plus4);
            pc_d  = ADDR_WIDTH'(rs1_v + imm_i) & ~ADDR_WIDTH'(1);
          end
          OPC_BRANCH: begin
            if (br_taken) pc_d = pc + imm_b;
          end
          OPC_STORE: begin
            mem_addr  = ADDR_WIDTH'(rs1_v + imm_s);
            mem_data  = rs2_v;
            mem_write = 1'b1;
          end
          OPC_LOAD: begin
            mem_addr = ADDR_WIDTH'(rs1_v + imm_i);
            pc_d     = pc;
            state_d  = S_MEM;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        rf_we   = 1'b1;
        rf_wa   = rd_q;
        rf_wd   = mem_read;
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc      <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      addr_q  <= mem_addr;
      data_q  <= mem_data;
      if (state_q == S_EXEC) rd_q <= rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      regs[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_riscv_hart_core.sv
module tb_riscv_hart_core;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;

  riscv_hart_core #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .pc         (pc),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_write  (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        dmem_clr;

  always @(posedge clk) begin
    instruction <= imem[pc[7:2]];
    if (dmem_clr) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else if (mem_write) begin
      dmem[mem_addr[7:2]] <= mem_data;
    end else begin
      mem_read <= dmem[mem_addr[7:2]];
    end
  end

  int n_cmp;
  int n_fail;

  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;
  logic [31:0] prog [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] opc);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd, input logic [31:0] opc);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                        input logic [31:0] opc);
    return {imm20[19:0], rd[4:0], opc[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  // Instruction-set reference: executes one instruction at m_pc on the model
  // state and reports what the data memory port should show during EXEC.
  task automatic model_step(output bit ld, output bit st,
                            output logic [31:0] a, output logic [31:0] d);
    logic [31:0] ins, x, y, res, ii, is, ib, ij, iu, nxt;
    logic [4:0]  sh;
    bit          wr, tk;
    ins = imem[m_pc[7:2]];
    x   = m_regs[ins[19:15]];
    y   = m_regs[ins[24:20]];
    ii  = 32'($signed(ins[31:20]));
    is  = 32'($signed({ins[31:25], ins[11:7]}));
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    iu  = {ins[31:12], 12'h000};
    ld = 0; st = 0; a = 0; d = 0; wr = 0; res = 0; tk = 0;
    nxt = m_pc + 4;
    case (ins[6:0])
      7'h13, 7'h33: begin
        wr = 1;
        if (ins[6:0] == 7'h13) y = ii;
        sh = y[4:0];
        case (ins[14:12])
          3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? x - y : x + y;
          3'd1: res = x << sh;
          3'd2: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: res = (x < y) ? 32'd1 : 32'd0;
          3'd4: res = x ^ y;
          3'd5: res = ins[30] ? 32'($signed(x) >>> sh) : x >> sh;
          3'd6: res = x | y;
          default: res = x & y;
        endcase
      end
      7'h37: begin wr = 1; res = iu; end
      7'h17: begin wr = 1; res = m_pc + iu; end
      7'h6F: begin wr = 1; res = m_pc + 4; nxt = m_pc + ij; end
      7'h67: begin wr = 1; res = m_pc + 4; nxt = (x + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (ins[14:12])
          3'd0: tk = (x == y);
          3'd1: tk = (x != y);
          3'd4: tk = ($signed(x) <  $signed(y));
          3'd5: tk = ($signed(x) >= $signed(y));
          3'd6: tk = (x <  y);
          3'd7: tk = (x >= y);
          default: tk = 0;
        endcase
        if (tk) nxt = m_pc + ib;
      end
      7'h23: begin
        st = 1; a = x + is; d = y;
        m_dmem[a[7:2]] = d;
      end
      7'h03: begin
        ld = 1; wr = 1; a = x + ii;
        res = m_dmem[a[7:2]];
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    dmem_clr = 1'b1;
    m_pc     = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    for (int i = 0; i < 64; i++) m_dmem[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_we", {31'h0, mem_write}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_data", mem_data, 32'h0);
    dmem_clr = 1'b0;
    rst      = 1'b0;
  endtask

  // One instruction in lock-step: called with the DUT at a FETCH negedge.
  task automatic step();
    bit          ld, st;
    logic [31:0] a, d, old_pc;
    old_pc = m_pc;
    check("fetch_pc", pc, m_pc);
    check("fetch_we", {31'h0, mem_write}, 32'h0);
    model_step(ld, st, a, d);
    @(posedge clk); @(negedge clk);
    check("exec_we", {31'h0, mem_write}, {31'h0, st});
    if (st || ld) check("exec_addr", mem_addr, a);
    if (st) check("exec_data", mem_data, d);
    @(posedge clk); @(negedge clk);
    if (ld) begin
      check("mem_pc_hold", pc, old_pc);
      check("mem_we", {31'h0, mem_write}, 32'h0);
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic run(input logic [31:0] end_pc, input int max_steps);
    for (int s = 0; s < max_steps && m_pc != end_pc; s++) step();
    check("end_pc", pc, m_pc);
    for (int i = 0; i < 64; i++) check($sformatf("dmem[%0d]", i), dmem[i], m_dmem[i]);
  endtask

  task automatic gen_random(input int n);
    logic [31:0] rd, rs1, rs2, f3, imm, f7;
    int          k;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      k   = $urandom_range(0, 9);
      rd  = $urandom_range(1, 15);
      rs1 = $urandom_range(0, 15);
      rs2 = $urandom_range(0, 15);
      f3  = $urandom_range(0, 7);
      imm = $urandom_range(0, 4095);
      case (k)
        0, 1: begin
          if (f3 == 1) imm = imm & 32'h1F;
          if (f3 == 5) imm = (imm & 32'h41F);
          prog.push_back(enc_i(imm, rs1, f3, rd, 32'h13));
        end
        2, 3: begin
          f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32'h20 : 32'h0;
          prog.push_back(enc_r(f7, rs2, rs1, f3, rd, 32'h33));
        end
        4: prog.push_back(enc_u($urandom, rd, ($urandom_range(0, 1) == 1) ? 32'h37 : 32'h17));
        5: prog.push_back(enc_s($urandom_range(0, 159), rs2, 0, f3));
        6: prog.push_back(enc_i($urandom_range(0, 159), 0, f3, rd, 32'h03));
        7: begin
          case ($urandom_range(0, 5))
            0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
          endcase
          prog.push_back(enc_b(8, rs2, rs1, f3));
        end
        8: prog.push_back(enc_j(8, rd));
        default: begin
          case ($urandom_range(0, 2))
            0: prog.push_back(32'h0000_0000);
            1: prog.push_back(32'h0000_000F);
            default: prog.push_back(32'h0000_0073);
          endcase
        end
      endcase
    end
    for (int r = 1; r < 16; r++) prog.push_back(enc_s((39 + r) * 4, r, 0, 2));
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    dmem_clr = 1'b1;

    // All-zero ROM: pc walks 0,4,8,... and no store ever issues
    prog.delete();
    load_prog();
    do_reset();
    run(32'h20, 8);

    // ADD / SUB
    prog = '{enc_i(5, 0, 0, 1, 32'h13), enc_i(-3, 0, 0, 2, 32'h13),
             enc_r(0, 2, 1, 0, 3, 32'h33), enc_s(0, 3, 0, 2),
             enc_r(32'h20, 2, 1, 0, 4, 32'h33), enc_s(4, 4, 0, 2)};
    load_prog();
    do_reset();
    run(32'h18, 20);
    check("add_word0", dmem[0], 32'h0000_0002);
    check("sub_word1", dmem[1], 32'h0000_0008);

    // Reset asserted during EXEC of a store aborts it at once
    do_reset();
    for (int i = 0; i < 3; i++) step();
    @(posedge clk); @(negedge clk);
    check("abort_pre_we", {31'h0, mem_write}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_we", {31'h0, mem_write}, 32'h0);
    check("abort_pc", pc, 32'h0);
    @(posedge clk); @(negedge clk);
    check("abort_word0", dmem[0], 32'h0);

    // Registers cleared by reset
    prog = '{enc_s(0, 3, 0, 2), enc_s(4, 1, 0, 2)};
    load_prog();
    do_reset();
    dmem_clr = 1'b0;
    run(32'h8, 10);
    check("rst_x3", dmem[0], 32'h0);

    // Store / load / store
    prog = '{enc_u(1, 1, 32'h37), enc_i(32'h234, 1, 0, 1, 32'h13),
             enc_s(8, 1, 0, 2), enc_i(8, 0, 2, 4, 32'h03), enc_s(12, 4, 0, 2)};
    load_prog();
    do_reset();
    run(32'h14, 20);
    check("ld_word2", dmem[2], 32'h0000_1234);
    check("ld_word3", dmem[3], 32'h0000_1234);

    // Countdown loop with BNE
    prog = '{enc_i(9, 0, 0, 2, 32'h13), enc_s(0, 2, 0, 2), enc_i(3, 0, 0, 1, 32'h13),
             enc_i(-1, 1, 0, 1, 32'h13), enc_b(-4, 0, 1, 1), enc_s(0, 1, 0, 2)};
    load_prog();
    do_reset();
    run(32'h18, 30);
    check("loop_word0", dmem[0], 32'h0);

    // JAL / JALR / LUI
    prog = '{32'h13, 32'h13, 32'h13, 32'h13, enc_j(8, 1), enc_u(32'hABCDE, 5, 32'h37),
             enc_b(12, 0, 5, 1), enc_s(0, 1, 0, 2), enc_i(0, 1, 0, 0, 32'h67),
             enc_s(4, 5, 0, 2)};
    load_prog();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("jal_pc", pc, 32'h18);
    run(32'h28, 20);
    check("jal_link", dmem[0], 32'h0000_0014);
    check("lui_word1", dmem[1], 32'hABCD_E000);

    // Randomized programs against the reference model
    for (int p = 0; p < 3; p++) begin
      gen_random(40);
      load_prog();
      do_reset();
      run(prog.size() * 4, 120);
    end

    // Compare / shift / x0
    prog = '{enc_i(-1, 0, 0, 1, 32'h13), enc_i(1, 0, 0, 2, 32'h13),
             enc_r(0, 2, 1, 2, 3, 32'h33), enc_r(0, 2, 1, 3, 4, 32'h33),
             enc_i(32'h404, 1, 5, 5, 32'h13), enc_i(4, 1, 5, 6, 32'h13),
             enc_i(7, 0, 0, 0, 32'h13),
             enc_s(0, 3, 0, 2), enc_s(4, 4, 0, 2), enc_s(8, 5, 0, 2),
             enc_s(12, 6, 0, 2), enc_s(16, 0, 0, 2), enc_s(20, 7, 0, 2)};
    load_prog();
    do_reset();
    run(32'h34, 20);
    check("slt", dmem[0], 32'h1);
    check("sltu", dmem[1], 32'h0);
    check("srai", dmem[2], 32'hFFFF_FFFF);
    check("srli", dmem[3], 32'h0FFF_FFFF);
    check("x0_zero", dmem[4], 32'h0);
    check("x7_clear", dmem[5], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
